// File: rtl/mem_pkg.sv
// Shared definitions for the load/store memory path: access sizes, responder
// states and the chip-select code of the data RAM.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10,
        ST_HOLD = 2'b11
    } state_e;

    localparam logic [1:0] CS_DATA = 2'b01;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    // Byte lanes relative to the access base address.
    function automatic logic [7:0] lane_mask(input logic [1:0] size);
        logic [7:0] mask;
        unique case (size_e'(size))
            SZ_BYTE:  mask = 8'h01;
            SZ_HALF:  mask = 8'h03;
            SZ_WORD:  mask = 8'h0F;
            default:  mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store bus between the control unit (master) and the data RAM responder (slave).
interface data_mem_responder_if;

    logic [1:0]  mem_cs;
    logic        mem_write_en;
    logic [1:0]  size;
    logic [63:0] address;
    logic [63:0] data_in;
    logic [63:0] data_out;
    logic        data_oe;
    logic        ready;
    logic        err;

    modport master (
        output mem_cs, mem_write_en, size, address, data_in,
        input  data_out, data_oe, ready, err
    );

    modport slave (
        input  mem_cs, mem_write_en, size, address, data_in,
        output data_out, data_oe, ready, err
    );

endinterface

// File: rtl/byte_lane_ram.sv
// Byte-addressable RAM with an 8-lane write port and an 8-byte registered read
// port, both anchored at a common base address; disabled read lanes return zero.
module byte_lane_ram #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [7:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [63:0]   i_wdata,
    output logic [63:0]   o_rdata
);

    logic [7:0]  r_mem [DEPTH];
    logic [63:0] r_rdata;

    // NOTE: the array is deliberately left out of reset so it maps onto RAM macros.
    always_ff @(posedge clock) begin
        if (i_we) begin
            for (int k = 0; k < 8; k++) begin
                if (i_be[k]) begin
                    r_mem[i_addr + AW'(k)] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            for (int k = 0; k < 8; k++) begin
                r_rdata[8*k +: 8] <= i_be[k] ? r_mem[i_addr + AW'(k)] : 8'h00;
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Data-RAM responder: captures one load/store per chip-select assertion, waits
// WAIT_STATES cycles, commits to the RAM, then holds ready until select drops.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int         DEPTH       = 1024,
    parameter int         WAIT_STATES = 2,
    parameter logic [1:0] CS_ID       = CS_DATA
) (
    input logic                 clock,
    input logic                 reset,
    data_mem_responder_if.slave bus
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e      r_state;
    state_e      w_next_state;
    logic [3:0]  r_wait_cnt;
    logic        r_write;
    logic [1:0]  r_size;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic        r_ready;
    logic        r_data_oe;
    logic        r_err;

    logic        w_hit;
    logic        w_write;
    logic [1:0]  w_size;
    logic [63:0] w_addr;
    logic [63:0] w_wdata;
    logic [3:0]  w_bytes;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_err;
    logic [7:0]  w_lanes;
    logic        w_commit;
    logic        w_ready_d;
    logic        w_data_oe_d;
    logic        w_err_d;
    logic [63:0] w_rdata;

    assign w_hit = (bus.mem_cs == CS_ID);

    // In IDLE the live bus is the request, so a zero-wait commit sees it on the capture edge.
    assign w_write = (r_state == ST_IDLE) ? bus.mem_write_en : r_write;
    assign w_size  = (r_state == ST_IDLE) ? bus.size         : r_size;
    assign w_addr  = (r_state == ST_IDLE) ? bus.address      : r_addr;
    assign w_wdata = (r_state == ST_IDLE) ? bus.data_in      : r_wdata;

    assign w_bytes        = size_bytes(w_size);
    assign w_misaligned   = (w_addr[2:0] & 3'(w_bytes - 4'd1)) != 3'd0;
    assign w_out_of_range = ({1'b0, w_addr} + 65'(w_bytes)) > 65'(DEPTH);
    assign w_err          = w_misaligned | w_out_of_range;
    assign w_lanes        = w_err ? 8'h00 : lane_mask(w_size);

    assign w_commit = !reset &&
                      (((r_state == ST_IDLE) && w_hit && (WAIT_STATES == 0)) ||
                       ((r_state == ST_BUSY) && (r_wait_cnt == 4'd0)));

    // Errored accesses still fire a read with no lanes so data_out reads back as zero.
    byte_lane_ram #(.DEPTH(DEPTH)) u_ram (
        .clock   (clock),
        .reset   (reset),
        .i_we    (w_commit & w_write & ~w_err),
        .i_re    (w_commit & (~w_write | w_err)),
        .i_be    (w_lanes),
        .i_addr  (w_addr[AW-1:0]),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_write    <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ready    <= 1'b0;
            r_data_oe  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_ready   <= w_ready_d;
            r_data_oe <= w_data_oe_d;
            r_err     <= w_err_d;
            if ((r_state == ST_IDLE) && w_hit) begin
                r_write    <= bus.mem_write_en;
                r_size     <= bus.size;
                r_addr     <= bus.address;
                r_wdata    <= bus.data_in;
                r_wait_cnt <= WAIT_LOAD;
            end else if ((r_state == ST_BUSY) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        // NOTE: default assignment first so no latch is inferred on any path.
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (w_hit) w_next_state = (WAIT_STATES == 0) ? ST_RESP : ST_BUSY;
            ST_BUSY: if (r_wait_cnt == 4'd0) w_next_state = ST_RESP;
            ST_RESP: w_next_state = ST_HOLD;
            ST_HOLD: if (!w_hit) w_next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered: asserted on the edge leaving RESP, dropped with select.
    always_comb begin
        w_ready_d   = (r_state == ST_RESP) || ((r_state == ST_HOLD) && w_hit);
        w_data_oe_d = w_ready_d && !r_write;
        w_err_d     = w_ready_d && w_err;
    end

    assign bus.ready    = r_ready;
    assign bus.data_oe  = r_data_oe;
    assign bus.err      = r_err;
    assign bus.data_out = w_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: stores, loads, sub-word
// merges, alignment/range errors, held select, reset mid-access and foreign select.
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int DEPTH   = 1024;
    localparam int WAIT    = 2;
    localparam int TIMEOUT = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_STATES (WAIT),
        .CS_ID       (CS_DATA)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge; runs one full handshake and checks it.
    task automatic access(input string tag, input logic we, input logic [1:0] sz,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input logic exp_err, input logic chk_data, input logic [63:0] exp_data);
        int n;
        bus.mem_cs       = CS_DATA;
        bus.mem_write_en = we;
        bus.size         = sz;
        bus.address      = addr;
        bus.data_in      = wd;
        @(posedge clock);
        n = 0;
        while (n < TIMEOUT) begin
            @(negedge clock);
            if (bus.ready === 1'b1) break;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(1 + WAIT));
        check({tag, " err"}, 64'(bus.err), 64'(exp_err));
        check({tag, " data_oe"}, 64'(bus.data_oe), 64'(!we));
        if (chk_data) check({tag, " data_out"}, bus.data_out, exp_data);
        bus.mem_cs  = 2'b00;
        bus.address = ~addr;
        bus.data_in = ~wd;
        @(negedge clock);
        check({tag, " ready drop"}, 64'(bus.ready), 64'd0);
        check({tag, " oe/err drop"}, {62'd0, bus.data_oe, bus.err}, 64'd0);
        if (chk_data) check({tag, " data_out kept"}, bus.data_out, exp_data);
    endtask

    initial begin
        logic [63:0] p_val;
        int          rises;
        int          rdy_cnt;
        logic        prev;

        p_val            = 64'h0123_4567_89AB_CDEF;
        bus.mem_cs       = 2'b00;
        bus.mem_write_en = 1'b0;
        bus.size         = SZ_BYTE;
        bus.address      = '0;
        bus.data_in      = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset outputs", {61'd0, bus.ready, bus.data_oe, bus.err}, 64'd0);
        check("reset data_out", bus.data_out, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Full-width store and load-back.
        access("stur 0x10", 1'b1, SZ_DWORD, 64'h10, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 64'd0);
        access("ldur 0x10", 1'b0, SZ_DWORD, 64'h10, 64'd0, 1'b0, 1'b1, 64'h1122_3344_5566_7788);

        // Byte store merges into the middle of the doubleword.
        access("sturb 0x13", 1'b1, SZ_BYTE, 64'h13, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 1'b0, 64'd0);
        access("ldur merged", 1'b0, SZ_DWORD, 64'h10, 64'd0, 1'b0, 1'b1, 64'h1122_3344_AB66_7788);
        access("ldurb 0x13", 1'b0, SZ_BYTE, 64'h13, 64'd0, 1'b0, 1'b1, 64'h0000_0000_0000_00AB);
        access("ldur half 0x12", 1'b0, SZ_HALF, 64'h12, 64'd0, 1'b0, 1'b1, 64'h0000_0000_0000_AB66);
        access("ldur word 0x14", 1'b0, SZ_WORD, 64'h14, 64'd0, 1'b0, 1'b1, 64'h0000_0000_1122_3344);

        // Misaligned accesses.
        access("ldur mis 0x14", 1'b0, SZ_DWORD, 64'h14, 64'd0, 1'b1, 1'b1, 64'd0);
        access("stur 0x08", 1'b1, SZ_DWORD, 64'h08, 64'h0807_0605_0403_0201, 1'b0, 1'b0, 64'd0);
        access("stur mis 0x0c", 1'b1, SZ_DWORD, 64'h0C, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 64'd0);
        access("ldur 0x08 intact", 1'b0, SZ_DWORD, 64'h08, 64'd0, 1'b0, 1'b1, 64'h0807_0605_0403_0201);

        // Range boundary: last doubleword is legal, anything past the end is not.
        access("stur top", 1'b1, SZ_DWORD, 64'(DEPTH - 8), 64'hA5A5_5A5A_C3C3_3C3C, 1'b0, 1'b0, 64'd0);
        access("stur oor", 1'b1, SZ_DWORD, 64'(DEPTH - 4), 64'd0, 1'b1, 1'b1, 64'd0);
        access("sturw oor", 1'b1, SZ_WORD, 64'(DEPTH), 64'd0, 1'b1, 1'b1, 64'd0);
        access("ldur top intact", 1'b0, SZ_DWORD, 64'(DEPTH - 8), 64'd0, 1'b0, 1'b1, 64'hA5A5_5A5A_C3C3_3C3C);

        // Held select: one response, one write, later bus changes ignored.
        bus.mem_cs       = CS_DATA;
        bus.mem_write_en = 1'b1;
        bus.size         = SZ_DWORD;
        bus.address      = 64'h30;
        bus.data_in      = 64'hCAFE_0000_0000_0001;
        @(posedge clock);
        @(negedge clock);
        bus.address = 64'h38;
        bus.data_in = 64'hCAFE_0000_0000_0002;
        prev  = 1'b0;
        rises = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (bus.ready && !prev) rises++;
            prev = bus.ready;
            if (i == 5) bus.data_in = 64'hCAFE_0000_0000_0003;
        end
        check("held ready rises", 64'(rises), 64'd1);
        check("held ready still high", 64'(bus.ready), 64'd1);
        bus.mem_cs = 2'b00;
        @(negedge clock);
        access("ldur held 0x30", 1'b0, SZ_DWORD, 64'h30, 64'd0, 1'b0, 1'b1, 64'hCAFE_0000_0000_0001);

        // Reset while BUSY discards the pending store.
        access("stur 0x20", 1'b1, SZ_DWORD, 64'h20, p_val, 1'b0, 1'b0, 64'd0);
        bus.mem_cs       = CS_DATA;
        bus.mem_write_en = 1'b1;
        bus.size         = SZ_DWORD;
        bus.address      = 64'h20;
        bus.data_in      = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clock);
        @(negedge clock);
        reset      = 1'b1;
        bus.mem_cs = 2'b00;
        @(negedge clock);
        reset   = 1'b0;
        rdy_cnt = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus.ready) rdy_cnt++;
        end
        check("busy reset ready", 64'(rdy_cnt), 64'd0);

        // Reset wins over a request on the same edge.
        bus.mem_cs = CS_DATA;
        reset      = 1'b1;
        @(negedge clock);
        reset      = 1'b0;
        bus.mem_cs = 2'b00;
        rdy_cnt    = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus.ready) rdy_cnt++;
        end
        check("reset priority ready", 64'(rdy_cnt), 64'd0);

        // Foreign chip-select code is never acknowledged.
        bus.mem_cs = 2'b10;
        rdy_cnt    = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.ready) rdy_cnt++;
        end
        check("cs10 ready count", 64'(rdy_cnt), 64'd0);
        bus.mem_cs = 2'b00;
        @(negedge clock);
        access("ldur 0x20 intact", 1'b0, SZ_DWORD, 64'h20, 64'd0, 1'b0, 1'b1, p_val);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the load/store path driven by the control unit's control word fields `mem_cs`, `mem_write_en` and `size`, plus the datapath address and store-data buses.
- Holds a byte-addressable little-endian data RAM and serves STUR/STURB/LDUR/LDURB-class accesses with configurable wait states.
- Signals completion with `ready`, which lets the control unit's load/store state machine advance.
- Read data is driven onto the shared data bus through `data_oe`, which maps to the data tri-state at top level.

Parameters:
- DEPTH, 1024, data RAM size in bytes; must be a power of two.
- WAIT_STATES, 2, extra cycles between request capture and response (0..15).
- CS_ID, 2'b01, `mem_cs` code that selects this block.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- mem_cs  in  2  chip-select code from control word
- mem_write_en  in  1  1 = store, 0 = load
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 doubleword
- address  in  64  byte address from ALU
- data_in  in  64  store data (register B output)
- data_out  out  64  load data, zero-extended
- data_oe  out  1  drive data_out onto shared bus
- ready  out  1  access complete
- err  out  1  misaligned or out-of-range access; valid while ready=1

Behaviour:
- Clock and reset: one clock, `clock`; `reset` is synchronous and active-high.
- Reset values: state IDLE, data_out=0, data_oe=0, ready=0, err=0, wait counter=0. RAM contents are not cleared.
- Request: in IDLE, a rising edge with `mem_cs==CS_ID` captures address, data_in, size and mem_write_en into request registers. Any other `mem_cs` value is ignored.
- FSM states: IDLE, BUSY, RESP, HOLD.
- IDLE -> BUSY on request when WAIT_STATES>0 (counter loaded with WAIT_STATES-1). IDLE -> RESP on request when WAIT_STATES=0.
- BUSY: decrement each cycle; at counter==0 -> RESP.
- Latency: request sampled at edge t gives ready=1 from edge t+1+WAIT_STATES.
- Commit: the write, or the read of the RAM into data_out, happens on the edge entering RESP. Before that edge the RAM is untouched.
- Writes: write 1/2/4/8 bytes little-endian at the captured address (byte enables from size and address low bits).
- Reads: assemble 1/2/4/8 bytes little-endian and zero-extend to 64 bits.
- RESP: ready=1; data_oe=1 only for reads. Next state is HOLD.
- HOLD: ready, data_oe, data_out and err held stable while `mem_cs==CS_ID`. When `mem_cs!=CS_ID` -> IDLE on that edge, clearing ready, data_oe and err; data_out keeps its last value.
- One access per chip-select assertion: a held `mem_cs` never re-triggers.
- Errors: err=1 when the address is not a multiple of the access size, or when address+bytes > DEPTH. On error, no write, data_out=0, the handshake timing is unchanged, and err is asserted with ready.
- Changes to address, data_in, size or mem_write_en after capture have no effect.
- Reset mid-operation: reset in BUSY returns to IDLE and discards the pending write (RAM unchanged). Reset in RESP or HOLD clears outputs.
- Reset takes priority over a same-edge request.

Decomposition:
- Shared package `mem_pkg`:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - responder state encoding;
  - CS_DATA=2'b01;
  - function `size_bytes(size)` returning 1/2/4/8.
- Sub-module `byte_lane_ram`: DEPTH-byte array with an 8-lane byte-enable write port and an 8-byte read port at a base address. Synchronous write, registered read on commit.
- The responder holds the FSM, request registers, alignment/range check, lane steering and zero-extension.

Test Plan:
- STUR, WAIT_STATES=2: store 0x1122334455667788 at 0x10, request edge t -> ready=1 at t+3, err=0, data_oe=0. A following LDUR 0x10 returns data_out=0x1122334455667788 with data_oe=1.
- STURB then LDUR: STURB data_in=0x...AB at 0x13, then LDUR 0x10 -> 0x11223344AB667788. LDURB 0x13 -> 0x00000000000000AB.
- Misaligned: LDUR at 0x14 (size=11) -> ready at t+3, err=1, data_out=0. STUR at 0x0C -> err=1 and RAM at 0x08..0x0F unchanged.
- Out of range: STUR at DEPTH-4 -> err=1, no write.
- Held select: `mem_cs=01` held 8 cycles with a store -> exactly one ready rising edge and one write. Changing data_in during HOLD leaves memory unchanged.
- Reset mid-BUSY: STUR 0xDEADBEEF... at 0x20, reset asserted at t+1 -> ready stays 0, state IDLE, and a later LDUR 0x20 returns the prior contents. `mem_cs=10` is never acknowledged.
